// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: pops bytes from the UART receive buffer, parses 7E/LEN/payload/CHK frames
// and streams checksum-clean payloads on out_*. Define FRAME_TIMEOUT_EN to abort stalled partial frames.
module uart_rx_deframer #(
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] uart_rxcount,
  input  logic [7:0]  uart_dout,
  output logic [15:0] uart_id,
  output logic [15:0] uart_din,
  output logic        uart_write,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_good,
  output logic        frame_bad,
  output logic        len_err,
  output logic        timeout,
  output logic [7:0]  bad_cnt
);
  localparam int             AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]     MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [7:0]     SOF      = 8'h7E;
  localparam logic [15:0]    UART_ID  = 16'h0204;
  localparam logic [2:0]     SETTLE   = 3'd4;
  localparam logic [AW-1:0]  ADDR0    = '0;

  typedef enum logic [2:0] {WAIT_SOF, WAIT_LEN, WAIT_PAY, WAIT_CHK, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  settle_q, settle_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  rdptr_q, rdptr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        uart_write_q, uart_write_d;
  logic [15:0] uart_id_q, uart_id_d;
  logic        frame_good_q, frame_good_d;
  logic        frame_bad_q, frame_bad_d;
  logic        len_err_q, len_err_d;
  logic        timeout_q;
  logic [7:0]  bad_cnt_q, bad_cnt_d;
  logic [7:0]  chk_sum;
  logic        mem_we;
  logic [AW-1:0] mem_wa;
  logic        take;
  logic        fire_tmo;

  logic [7:0]  pay_mem [2**AW];

  assign take = (uart_rxcount != 12'd0) && (settle_q == 3'd0) && enable && (state_q != DRAIN);

`ifdef FRAME_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT24 = 24'(TIMEOUT);
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic        active;

  // Counter runs only between bytes of a partial frame and freezes while enable is low.
  always_comb begin
    active    = state_q inside {WAIT_LEN, WAIT_PAY, WAIT_CHK};
    tmo_cnt_d = tmo_cnt_q;
    fire_tmo  = 1'b0;
    if (take || !active) begin
      tmo_cnt_d = '0;
    end else if (enable) begin
      tmo_cnt_d = tmo_cnt_q + 24'd1;
      if (tmo_cnt_d == TIMEOUT24) begin
        fire_tmo  = 1'b1;
        tmo_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT == 0);
  assign fire_tmo = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    len_d        = len_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    rdptr_d      = rdptr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_good_d = 1'b0;
    frame_bad_d  = 1'b0;
    len_err_d    = 1'b0;
    bad_cnt_d    = bad_cnt_q;
    mem_we       = 1'b0;
    mem_wa       = idx_q[AW-1:0];
    chk_sum      = sum_q + uart_dout;
    uart_write_d = take;
    uart_id_d    = take ? UART_ID : 16'h0000;

    if (settle_q != 3'd0) settle_d = settle_q - 3'd1;

    if (take) begin
      // The pop takes four cycles to reach the UART head, so hold off until the new byte is there.
      settle_d = SETTLE;
      case (state_q)
        WAIT_SOF: if (uart_dout == SOF) state_d = WAIT_LEN;
        WAIT_LEN: begin
          if (uart_dout == 8'd0 || uart_dout > MAX_LEN8) begin
            len_err_d = 1'b1;
            state_d   = WAIT_SOF;
          end else begin
            len_d   = uart_dout;
            sum_d   = uart_dout;
            idx_d   = 8'd0;
            state_d = WAIT_PAY;
          end
        end
        WAIT_PAY: begin
          mem_we = 1'b1;
          idx_d  = idx_q + 8'd1;
          sum_d  = chk_sum;
          if (idx_d == len_q) state_d = WAIT_CHK;
        end
        WAIT_CHK: begin
          if (chk_sum == 8'd0) begin
            frame_good_d = 1'b1;
            state_d      = DRAIN;
            rdptr_d      = 8'd0;
            out_valid_d  = 1'b1;
            out_data_d   = pay_mem[ADDR0];
            out_last_d   = (len_q == 8'd1);
          end else begin
            frame_bad_d = 1'b1;
            state_d     = WAIT_SOF;
          end
        end
        default: ;
      endcase
    end else if (fire_tmo) begin
      state_d = WAIT_SOF;
    end

    if (state_q == DRAIN && out_ready) begin
      if (out_last_q) begin
        state_d     = WAIT_SOF;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = 8'h00;
      end else begin
        rdptr_d    = rdptr_q + 8'd1;
        out_data_d = pay_mem[rdptr_d[AW-1:0]];
        out_last_d = (rdptr_d == len_q - 8'd1);
      end
    end

    if ((frame_bad_d || len_err_d || fire_tmo) && bad_cnt_q != 8'hFF)
      bad_cnt_d = bad_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_SOF;
      settle_q     <= 3'd0;
      len_q        <= 8'd0;
      sum_q        <= 8'd0;
      idx_q        <= 8'd0;
      rdptr_q      <= 8'd0;
      out_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      uart_write_q <= 1'b0;
      uart_id_q    <= 16'h0000;
      frame_good_q <= 1'b0;
      frame_bad_q  <= 1'b0;
      len_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      bad_cnt_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      idx_q        <= idx_d;
      rdptr_q      <= rdptr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      uart_write_q <= uart_write_d;
      uart_id_q    <= uart_id_d;
      frame_good_q <= frame_good_d;
      frame_bad_q  <= frame_bad_d;
      len_err_q    <= len_err_d;
      timeout_q    <= fire_tmo;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) pay_mem[mem_wa] <= uart_dout;
  end

  assign uart_id    = uart_id_q;
  assign uart_din   = 16'h0000;
  assign uart_write = uart_write_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_good = frame_good_q;
  assign frame_bad  = frame_bad_q;
  assign len_err    = len_err_q;
  assign timeout    = timeout_q;
  assign bad_cnt    = bad_cnt_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: queue-based UART buffer model plus a frame-level reference parser.
module tb_uart_rx_deframer;
  localparam int MAX_LEN = 32;
  localparam int TMO     = 100;

  logic        clk = 1'b0;
  logic        reset, enable, out_ready;
  logic [11:0] uart_rxcount;
  logic [7:0]  uart_dout;
  logic [15:0] uart_id, uart_din;
  logic        uart_write;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic        frame_good, frame_bad, len_err, timeout;
  logic [7:0]  bad_cnt;

  always #5 clk = ~clk;

  uart_rx_deframer #(.MAX_LEN(MAX_LEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .uart_rxcount(uart_rxcount), .uart_dout(uart_dout),
    .uart_id(uart_id), .uart_din(uart_din), .uart_write(uart_write),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_good(frame_good), .frame_bad(frame_bad), .len_err(len_err), .timeout(timeout),
    .bad_cnt(bad_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // UART receive buffer
  logic [7:0] uq[$];
  task automatic upd();
    uart_rxcount = 12'(uq.size());
    uart_dout    = (uq.size() != 0) ? uq[0] : 8'h00;
  endtask

  // Reference parser working on whole bytes
  int         m_st;
  int         m_len;
  logic [7:0] m_pay[$];
  logic [8:0] exp_q[$];
  int         e_good, e_bad, e_len, e_tmo, e_badcnt;

  task automatic model_err();
    if (e_badcnt < 255) e_badcnt++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int s;
    case (m_st)
      0: if (b == 8'h7E) m_st = 1;
      1: begin
        if (b == 0 || int'(b) > MAX_LEN) begin e_len++; model_err(); m_st = 0; end
        else begin m_len = int'(b); m_pay.delete(); m_st = 2; end
      end
      2: begin m_pay.push_back(b); if (m_pay.size() == m_len) m_st = 3; end
      default: begin
        s = m_len + int'(b);
        foreach (m_pay[i]) s += int'(m_pay[i]);
        if (s % 256 == 0) begin
          e_good++;
          foreach (m_pay[i]) exp_q.push_back({(i == m_len - 1), m_pay[i]});
        end else begin
          e_bad++; model_err();
        end
        m_st = 0;
      end
    endcase
  endtask

  task automatic pb(input logic [7:0] b);
    uq.push_back(b);
    model_byte(b);
    upd();
  endtask

  task automatic send_frame(input int len, input bit corrupt);
    logic [7:0] s, b;
    pb(8'h7E); pb(8'(len));
    s = 8'(len);
    for (int i = 0; i < len; i++) begin b = 8'($urandom); s += b; pb(b); end
    b = 8'd0 - s;
    if (corrupt) b += 8'($urandom_range(1, 255));
    pb(b);
  endtask

  // Observation
  logic [8:0] obs_q[$];
  int n_good, n_bad, n_len, n_tmo, n_wr;
  int cyc = 0, first_wr = -1, last_wr = -1, gap_ref = -1, tmo_cyc = -1;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_valid = 1'b0;
      gap_ref    = -1;
    end else begin
      chk("uart_din", 32'(uart_din), 32'h0);
      if (uart_write) begin
        chk("uart_id_on", 32'(uart_id), 32'h0204);
        if (gap_ref >= 0) chk("pop_gap_ge5", 32'(cyc - gap_ref >= 5), 32'd1);
        gap_ref = cyc;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        n_wr++;
        if (uq.size() != 0) void'(uq.pop_front());
        upd();
      end else begin
        chk("uart_id_off", 32'(uart_id), 32'h0);
      end
      if (prev_valid) chk("no_pop_in_drain", 32'(uart_write), 32'd0);
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
      if (frame_good) begin
        n_good++;
        chk("good_at_take", 32'(uart_write), 32'd1);
        chk("good_valid", 32'(out_valid), 32'd1);
      end
      if (frame_bad) begin
        n_bad++;
        chk("bad_at_take", 32'(uart_write), 32'd1);
        chk("bad_no_valid", 32'(out_valid), 32'd0);
      end
      if (len_err) begin n_len++; chk("lenerr_at_take", 32'(uart_write), 32'd1); end
      if (timeout) begin n_tmo++; tmo_cyc = cyc; end
      prev_valid = out_valid; prev_ready = out_ready;
      prev_data  = out_data;  prev_last  = out_last;
    end
  end

  task automatic clear_seg();
    obs_q.delete(); exp_q.delete();
    n_good = 0; n_bad = 0; n_len = 0; n_tmo = 0; n_wr = 0;
    e_good = 0; e_bad = 0; e_len = 0; e_tmo = 0;
    first_wr = -1; last_wr = -1; tmo_cyc = -1;
  endtask

  task automatic model_reset();
    m_st = 0; m_pay.delete(); e_badcnt = 0;
  endtask

  bit rmode = 1'b0;
  task automatic wait_idle(input string tag, input int maxc);
    int idle = 0;
    int k = 0;
    while (idle < 12 && k < maxc) begin
      @(posedge clk); #1;
      out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (uq.size() == 0 && !out_valid) idle++; else idle = 0;
      k++;
    end
    out_ready = 1'b1;
    if (idle < 12) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 400) begin @(posedge clk); #1; k++; end
    if (!out_valid) chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic seg_check(input string tag);
    int n;
    chk({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_good"},   32'(n_good), 32'(e_good));
    chk({tag, "_bad"},    32'(n_bad),  32'(e_bad));
    chk({tag, "_lenerr"}, 32'(n_len),  32'(e_len));
    chk({tag, "_tmo"},    32'(n_tmo),  32'(e_tmo));
    chk({tag, "_badcnt"}, 32'(bad_cnt), 32'(e_badcnt));
    clear_seg();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [7:0] d0;
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
    upd(); model_reset(); clear_seg();
    cycles(3);
    chk("rst_uart_write", 32'(uart_write), 32'd0);
    chk("rst_uart_id",    32'(uart_id),    32'h0);
    chk("rst_uart_din",   32'(uart_din),   32'h0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_last",   32'(out_last),   32'd0);
    chk("rst_out_data",   32'(out_data),   32'h0);
    chk("rst_pulses",     32'({frame_good, frame_bad, len_err, timeout}), 32'h0);
    chk("rst_bad_cnt",    32'(bad_cnt),    32'h0);
    reset = 1'b0;

    // Good frame, full-rate pops
    pb(8'h7E); pb(8'h03); pb(8'h11); pb(8'h22); pb(8'h33); pb(8'h97);
    wait_idle("good", 400);
    chk("good_pops", 32'(n_wr), 32'd6);
    chk("good_pop_span", 32'(last_wr - first_wr), 32'd25);
    chk("good_n_out", 32'(obs_q.size()), 32'd3);
    seg_check("good");

    // Bad checksum
    pb(8'h7E); pb(8'h02); pb(8'hAA); pb(8'h55); pb(8'h00);
    wait_idle("badchk", 400);
    chk("badchk_cnt_const", 32'(bad_cnt), 32'd1);
    seg_check("badchk");

    // Resync over garbage
    pb(8'h00); pb(8'hFF); pb(8'h7E); pb(8'h01); pb(8'h5A); pb(8'hA5);
    wait_idle("resync", 400);
    seg_check("resync");

    // Length errors then good frames at both length extremes
    pb(8'h7E); pb(8'h00); pb(8'h7E); pb(8'h21);
    send_frame(MAX_LEN, 1'b0); send_frame(1, 1'b0);
    wait_idle("lenerr", 2000);
    seg_check("lenerr");

    // Backpressure across two queued frames
    out_ready = 1'b0;
    send_frame(3, 1'b0); send_frame(3, 1'b0);
    wait_valid("bp");
    w0 = n_wr; d0 = out_data;
    cycles(20);
    chk("bp_no_pop", 32'(n_wr), 32'(w0));
    chk("bp_hold_data", 32'(out_data), 32'(d0));
    chk("bp_queue", 32'(uq.size()), 32'd6);
    wait_idle("bp", 600);
    seg_check("bp");

    // Enable drop mid-frame
    pb(8'h7E); pb(8'h02); pb(8'h10); pb(8'h20); pb(8'hCE);
    begin
      int k = 0;
      while (n_wr < 3 && k < 200) begin @(posedge clk); #1; k++; end
    end
    enable = 1'b0;
    cycles(2);
    w0 = n_wr;
    cycles(150);
    chk("en_freeze", 32'(n_wr), 32'(w0));
    chk("en_no_err", 32'(n_bad + n_len + n_tmo), 32'd0);
    enable = 1'b1;
    wait_idle("en", 400);
    seg_check("en");

    // Stalled partial frame
    pb(8'h7E); pb(8'h04); pb(8'h11);
    wait_idle("stall", 400);
    cycles(150);
`ifdef FRAME_TIMEOUT_EN
    chk("tmo_pulse", 32'(n_tmo), 32'd1);
    chk("tmo_delay", 32'(tmo_cyc - last_wr), 32'(TMO));
    m_st = 0; e_tmo++; model_err();
`else
    chk("no_tmo_pulse", 32'(n_tmo), 32'd0);
`endif
    pb(8'h22); pb(8'h33); pb(8'h44); pb(8'h52);
    send_frame(2, 1'b0);
    wait_idle("stall", 800);
    seg_check("stall");

    // Reset mid-frame
    pb(8'h7E); pb(8'h05); pb(8'h01); pb(8'h02);
    wait_idle("rstf", 400);
    reset = 1'b1; cycles(1);
    chk("rstf_badcnt", 32'(bad_cnt), 32'd0);
    reset = 1'b0; model_reset(); clear_seg();
    send_frame(5, 1'b0);
    wait_idle("rstf", 600);
    seg_check("rstf");

    // Reset mid-drain
    out_ready = 1'b0;
    send_frame(4, 1'b0);
    wait_valid("rstd");
    chk("rstd_good", 32'(n_good), 32'd1);
    reset = 1'b1; cycles(1);
    chk("rstd_valid", 32'(out_valid), 32'd0);
    chk("rstd_last",  32'(out_last),  32'd0);
    reset = 1'b0; model_reset(); clear_seg();
    out_ready = 1'b1;
    cycles(15);
    chk("rstd_dropped", 32'(obs_q.size()), 32'd0);
    send_frame(1, 1'b0);
    wait_idle("rstd", 400);
    seg_check("rstd");

    // Randomized mix with random consumer stalls
    rmode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: send_frame($urandom_range(1, MAX_LEN), 1'b0);
        3:       send_frame($urandom_range(1, MAX_LEN), 1'b1);
        4: begin pb(8'h7E); pb(($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255))); end
        default: pb(8'($urandom_range(0, 8'h7D)));
      endcase
    end
    wait_idle("rand", 40000);
    seg_check("rand");
    rmode = 1'b0;

    // bad_cnt saturation
    for (int i = 0; i < 130; i++) begin pb(8'h7E); pb(8'h00); pb(8'h7E); pb(8'h21); end
    wait_idle("sat", 4000);
    chk("sat_const", 32'(bad_cnt), 32'hFF);
    seg_check("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
